enrg_trg_ctrl: RTL and testbench

Trigger controller for the energy-detector front end.
- Takes the NCH stretched, synchronous channel triggers and forms a programmable majority coincidence.
- Issues a one-cycle trigger to the readout, then enforces a readout hold, a programmable dead time and a re-arm condition.
- Holds the configuration registers, including the stretch length broadcast to the per-channel stretchers, and keeps accepted/lost trigger counters.

---
 rtl/enrg_trg_ctrl.sv | 168 ++++++++++++++++
 tb/tb_enrg_trg_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enrg_trg_ctrl.sv
// Energy-detector trigger controller.
// Forms a programmable majority coincidence from the registered channel
// triggers, issues a one-cycle trigger to the readout, then walks through a
// readout hold, a programmable dead time and a re-arm phase before accepting
// the next coincidence. Also owns the configuration registers and the
// accepted/lost trigger counters.
//
// Handshake note: there is no valid/ready pair on this block. CfgWr is a
// one-cycle strobe qualified by CfgAddr/CfgData. A written value is used
// from the following cycle. RdoBusy is a level from the readout: the
// controller stays in Hold for as long as it is high.
module enrg_trg_ctrl #(
  parameter int NCH = 5,
  parameter int CW  = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [NCH-1:0] TrgIn,
  input  logic           RdoBusy,
  input  logic           CfgWr,
  input  logic [2:0]     CfgAddr,
  input  logic [7:0]     CfgData,
  output logic [3:0]     StrchLen,
  output logic           TrgOut,
  output logic           Busy,
  output logic [CW-1:0]  TrgCnt,
  output logic [CW-1:0]  LostCnt,
  output logic [4:0]     state_dbg
);

  // One-hot controller states.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_FIRE  = 5'b00010,
    ST_HOLD  = 5'b00100,
    ST_DEAD  = 5'b01000,
    ST_REARM = 5'b10000
  } state_t;

  state_t         state;
  logic [NCH-1:0] mask;
  logic [3:0]     thresh;
  logic [7:0]     dead_time;
  logic [7:0]     dt_cnt;
  logic [NCH-1:0] trg_r;
  logic           coinc;
  logic           coinc_d;
  logic           coinc_rise;
  logic [3:0]     npop;
  logic           cnt_clr;
  logic           trg_inc;
  logic           lost_inc;

  assign state_dbg = state;

  // Configuration register file; addr4 is a pure strobe and addresses 5..7
  // are deliberately left undecoded.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      StrchLen  <= 4'd3;
      mask      <= '1;
      thresh    <= 4'd1;
      dead_time <= 8'd10;
    end else if (CfgWr) begin
      case (CfgAddr)
        3'd0:    StrchLen  <= CfgData[3:0];
        3'd1:    mask      <= CfgData[NCH-1:0];
        3'd2:    thresh    <= CfgData[3:0];
        3'd3:    dead_time <= CfgData;
        default: ;
      endcase
    end
  end

  assign cnt_clr = CfgWr && (CfgAddr == 3'd4);

  // Register the channel triggers once and delay the coincidence for edge detection.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      trg_r   <= '0;
      coinc_d <= 1'b0;
    end else begin
      trg_r   <= TrgIn;
      coinc_d <= coinc;
    end
  end

  // Majority coincidence on registered, masked channel hits; Thresh=0 disables it.
  always_comb begin
    npop = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      npop = npop + {3'b000, trg_r[i] & mask[i]};
    end
    coinc      = (thresh != 4'd0) && (npop >= thresh);
    coinc_rise = coinc && !coinc_d;
  end

  // Trigger sequencer: Idle -> Fire -> Hold -> Dead -> Rearm -> Idle, with registered TrgOut/Busy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      TrgOut <= 1'b0;
      Busy   <= 1'b0;
      dt_cnt <= 8'd0;
    end else begin
      TrgOut <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coinc) begin
            state  <= ST_FIRE;
            TrgOut <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        ST_FIRE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Hold always lasts at least one cycle; leaves once the readout is free.
          if (!RdoBusy) begin
            state  <= ST_DEAD;
            dt_cnt <= 8'd0;
          end
        end
        ST_DEAD: begin
          // Compared against the live register so a rewrite acts at once.
          dt_cnt <= dt_cnt + 8'd1;
          if (dt_cnt >= dead_time) begin
            state <= ST_REARM;
          end
        end
        ST_REARM: begin
          // Wait for the stretched pulse that caused the trigger to drop.
          if (!coinc) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trg_inc  = (state == ST_FIRE);
  assign lost_inc = coinc_rise && (state != ST_IDLE);

  // Accepted trigger counter: saturating, clear strobe beats increment.
  always_ff @(posedge Clock) begin
    if (Reset || cnt_clr) begin
      TrgCnt <= '0;
    end else if (trg_inc && (TrgCnt != {CW{1'b1}})) begin
      TrgCnt <= TrgCnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Lost coincidence counter: saturating, clear strobe beats increment.
  always_ff @(posedge Clock) begin
    if (Reset || cnt_clr) begin
      LostCnt <= '0;
    end else if (lost_inc && (LostCnt != {CW{1'b1}})) begin
      LostCnt <= LostCnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_enrg_trg_ctrl.sv
// Bench for enrg_trg_ctrl. Two instances share all inputs: one with the
// default counter width and one with a 3-bit counter so saturation is
// reachable quickly. Expected per-cycle TrgOut/Busy and counter values come
// from an edge-arithmetic model of the trigger rules.
`timescale 1ns/1ps
module tb_enrg_trg_ctrl;

  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int CWS = 3;
  localparam int N   = 90;
  localparam int MAXM = (1 << CW) - 1;
  localparam int MAXS = (1 << CWS) - 1;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] trg_in = '0;
  logic           rdo_busy = 1'b0;
  logic           cfg_wr = 1'b0;
  logic [2:0]     cfg_addr = '0;
  logic [7:0]     cfg_data = '0;

  logic [3:0]     strch_len, s_strch_len;
  logic           trg_out, s_trg_out;
  logic           busy, s_busy;
  logic [CW-1:0]  trg_cnt, lost_cnt;
  logic [CWS-1:0] s_trg_cnt, s_lost_cnt;
  logic [4:0]     state_dbg, s_state_dbg;

  always #5 clk = ~clk;

  enrg_trg_ctrl #(.NCH(NCH), .CW(CW)) u_dut (
    .Clock(clk), .Reset(rst), .TrgIn(trg_in), .RdoBusy(rdo_busy),
    .CfgWr(cfg_wr), .CfgAddr(cfg_addr), .CfgData(cfg_data),
    .StrchLen(strch_len), .TrgOut(trg_out), .Busy(busy),
    .TrgCnt(trg_cnt), .LostCnt(lost_cnt), .state_dbg(state_dbg)
  );

  enrg_trg_ctrl #(.NCH(NCH), .CW(CWS)) u_sat (
    .Clock(clk), .Reset(rst), .TrgIn(trg_in), .RdoBusy(rdo_busy),
    .CfgWr(cfg_wr), .CfgAddr(cfg_addr), .CfgData(cfg_data),
    .StrchLen(s_strch_len), .TrgOut(s_trg_out), .Busy(s_busy),
    .TrgCnt(s_trg_cnt), .LostCnt(s_lost_cnt), .state_dbg(s_state_dbg)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int exp_trg = 0, exp_lost = 0, exp_trg_s = 0, exp_lost_s = 0;
  int cur_th = 1, cur_dead = 10;
  logic [NCH-1:0] cur_mask = '1;
  logic [NCH-1:0] trg_a [0:N+1];
  logic           rdo_a [0:N+1];
  logic [3:0]     exp_q [$];   // {busy, trg_out, s_busy, s_trg_out} per cycle

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic set_cfg(input int th, input logic [NCH-1:0] m, input int d);
    cfg_write(3'd2, 8'(th));
    cfg_write(3'd1, 8'(m));
    cfg_write(3'd3, 8'(d));
    cur_th = th; cur_mask = m; cur_dead = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_trg = 0; exp_lost = 0; exp_trg_s = 0; exp_lost_s = 0;
    cur_th = 1; cur_mask = '1; cur_dead = 10;
  endtask

  task automatic clear_stim();
    for (int i = 0; i <= N + 1; i++) begin
      trg_a[i] = '0;
      rdo_a[i] = 1'b0;
    end
  endtask

  // ---------------- reference model ----------------
  // Coincidence present in the cycle following sampling edge e.
  function automatic bit coinc_at(input int e);
    int c;
    if (e < 1 || e > N) return 1'b0;
    c = 0;
    for (int i = 0; i < NCH; i++) c += int'(trg_a[e][i] & cur_mask[i]);
    return (cur_th != 0) && (c >= cur_th);
  endfunction

  function automatic bit rdo_at(input int e);
    if (e < 1 || e > N) return 1'b0;
    return rdo_a[e];
  endfunction

  function automatic int sat_add(input int v, input int n, input int m);
    return (v + n > m) ? m : v + n;
  endfunction

  // Runs one stimulus window of N edges and checks every cycle plus the counters.
  task automatic run_window(input string name);
    bit out_e  [0:N];
    bit busy_e [0:N];
    int free, h, e_end, nf, nl;
    logic [3:0] exp;
    for (int e = 0; e <= N; e++) begin out_e[e] = 0; busy_e[e] = 0; end
    free = 1; nf = 0; nl = 0;
    for (int e = 1; e <= N; e++) begin
      if (e >= free && coinc_at(e - 1)) begin
        out_e[e] = 1; nf++;
        h = e + 2;
        while (rdo_at(h)) h++;
        e_end = h + cur_dead + 2;
        while (coinc_at(e_end - 1)) e_end++;
        for (int j = e; j < e_end && j <= N; j++) busy_e[j] = 1;
        for (int j = e; j < e_end; j++)
          if (coinc_at(j) && !coinc_at(j - 1)) nl++;
        free = e_end + 1;
      end
    end
    for (int e = 1; e <= N; e++) exp_q.push_back({busy_e[e], out_e[e], busy_e[e], out_e[e]});

    trg_in = trg_a[1]; rdo_busy = rdo_a[1];
    for (int e = 1; e <= N; e++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({busy, trg_out, s_busy, s_trg_out} !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d busy/trg/sbusy/strg got %b expected %b",
                 name, e, {busy, trg_out, s_busy, s_trg_out}, exp);
      end
      if (e < N) begin trg_in = trg_a[e + 1]; rdo_busy = rdo_a[e + 1]; end
    end
    trg_in = '0; rdo_busy = 1'b0;

    exp_trg = sat_add(exp_trg, nf, MAXM);   exp_trg_s = sat_add(exp_trg_s, nf, MAXS);
    exp_lost = sat_add(exp_lost, nl, MAXM); exp_lost_s = sat_add(exp_lost_s, nl, MAXS);
    checks++;
    if (trg_cnt !== exp_trg[CW-1:0]) begin
      errors++; $display("FAIL %s trg_cnt got %0d expected %0d", name, trg_cnt, exp_trg);
    end
    checks++;
    if (lost_cnt !== exp_lost[CW-1:0]) begin
      errors++; $display("FAIL %s lost_cnt got %0d expected %0d", name, lost_cnt, exp_lost);
    end
    checks++;
    if (s_trg_cnt !== exp_trg_s[CWS-1:0]) begin
      errors++; $display("FAIL %s sat trg_cnt got %0d expected %0d", name, s_trg_cnt, exp_trg_s);
    end
    checks++;
    if (s_lost_cnt !== exp_lost_s[CWS-1:0]) begin
      errors++; $display("FAIL %s sat lost_cnt got %0d expected %0d", name, s_lost_cnt, exp_lost_s);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({trg_out, busy} !== 2'b00) begin
      errors++; $display("FAIL reset trg/busy got %b expected 00", {trg_out, busy});
    end
    checks++;
    if (strch_len !== 4'd3) begin
      errors++; $display("FAIL reset strch_len got %0d expected 3", strch_len);
    end
    checks++;
    if ({trg_cnt, lost_cnt} !== '0) begin
      errors++; $display("FAIL reset counters got %0d/%0d expected 0/0", trg_cnt, lost_cnt);
    end
    checks++;
    if ($onehot(state_dbg) !== 1'b1) begin
      errors++; $display("FAIL reset state onehot got %b expected one-hot", state_dbg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    clear_stim();
    for (int e = 1; e <= 4; e++) trg_a[e] = 5'b00100;
    run_window("single_pulse");
  endtask

  task automatic test_config();
    cfg_write(3'd0, 8'hA5);
    checks++;
    if (strch_len !== 4'd5) begin
      errors++; $display("FAIL cfg strch_len got %0d expected 5", strch_len);
    end
    cfg_write(3'd5, 8'h00);
    cfg_write(3'd6, 8'h00);
    cfg_write(3'd7, 8'h00);
    checks++;
    if (strch_len !== 4'd5) begin
      errors++; $display("FAIL cfg ignored addr strch_len got %0d expected 5", strch_len);
    end
    clear_stim();
    for (int e = 1; e <= 3; e++) trg_a[e] = 5'b01000;
    run_window("ignored_addr");
  endtask

  task automatic test_threshold();
    set_cfg(3, 5'b10111, 10);
    clear_stim();
    for (int e = 1; e <= 4; e++)   trg_a[e] = 5'b01011;
    for (int e = 30; e <= 33; e++) trg_a[e] = 5'b00111;
    run_window("threshold");
  endtask

  task automatic test_hold_lost();
    set_cfg(1, '1, 10);
    clear_stim();
    trg_a[1] = 5'b00001; trg_a[2] = 5'b00001;
    for (int e = 3; e <= 22; e++) rdo_a[e] = 1'b1;
    trg_a[8]  = 5'b00010; trg_a[9]  = 5'b00010;
    trg_a[14] = 5'b01000; trg_a[15] = 5'b01000;
    run_window("hold_lost");
  endtask

  task automatic test_back_to_back();
    set_cfg(1, '1, 0);
    clear_stim();
    trg_a[1] = 5'b00001;
    trg_a[6] = 5'b10000;
    run_window("back_to_back");
  endtask

  // DeadTime rewritten to 200 mid-dead: Fire + Hold + 201 Dead + 1 Rearm.
  task automatic test_dead_live();
    int cnt;
    bit done;
    set_cfg(1, '1, 10);
    trg_in = 5'b00001;
    tick();
    trg_in = '0;
    tick();
    checks++;
    if ({trg_out, busy} !== 2'b11) begin
      errors++; $display("FAIL dead_live fire got %b expected 11", {trg_out, busy});
    end
    cnt = 1; done = 0;
    for (int k = 3; k < 400 && !done; k++) begin
      if (k == 8) begin cfg_wr = 1'b1; cfg_addr = 3'd3; cfg_data = 8'd200; end
      tick();
      cfg_wr = 1'b0;
      if (busy) cnt++;
      else done = 1;
    end
    checks++;
    if (cnt !== 204) begin
      errors++; $display("FAIL dead_live busy cycles got %0d expected 204", cnt);
    end
    exp_trg = sat_add(exp_trg, 1, MAXM);
    exp_trg_s = sat_add(exp_trg_s, 1, MAXS);
    set_cfg(1, '1, 10);
  endtask

  task automatic test_random();
    logic [NCH-1:0] cur;
    bit r;
    for (int w = 0; w < 6; w++) begin
      set_cfg($urandom_range(0, NCH), NCH'($urandom_range(1, (1 << NCH) - 1)),
              $urandom_range(0, 6));
      clear_stim();
      cur = '0; r = 0;
      for (int e = 1; e <= 45; e++) begin
        if ($urandom_range(0, 2) == 0)
          cur = ($urandom_range(0, 1) == 1) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
        trg_a[e] = cur;
        if ($urandom_range(0, 4) == 0) r = !r;
        rdo_a[e] = r;
      end
      run_window("random");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_cfg(1, '1, 0);
    clear_stim();
    for (int k = 0; k < 10; k++) trg_a[1 + 6 * k] = 5'b00010;
    run_window("saturation");
    // Clear strobe landing in the Fire cycle must beat the increment.
    trg_in = 5'b00001;
    tick();
    trg_in = '0;
    tick();
    checks++;
    if (trg_out !== 1'b1) begin
      errors++; $display("FAIL clear_fire trg_out got %b expected 1", trg_out);
    end
    cfg_wr = 1'b1; cfg_addr = 3'd4; cfg_data = 8'h00;
    tick();
    cfg_wr = 1'b0;
    checks++;
    if ({trg_cnt, lost_cnt} !== '0 || {s_trg_cnt, s_lost_cnt} !== '0) begin
      errors++; $display("FAIL clear_fire counters got %0d/%0d sat %0d/%0d expected 0",
                         trg_cnt, lost_cnt, s_trg_cnt, s_lost_cnt);
    end
    exp_trg = 0; exp_lost = 0; exp_trg_s = 0; exp_lost_s = 0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clear_fire drain busy got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(2, 5'b00011, 50);
    cfg_write(3'd0, 8'd9);
    rdo_busy = 1'b1;
    trg_in = '1;
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid pre busy got %b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({trg_out, busy, strch_len} !== {2'b00, 4'd3}) begin
      errors++; $display("FAIL reset_mid trg/busy/strch got %b expected 000011",
                         {trg_out, busy, strch_len});
    end
    checks++;
    if ({trg_cnt, lost_cnt} !== '0 || {s_trg_cnt, s_lost_cnt} !== '0) begin
      errors++; $display("FAIL reset_mid counters got %0d/%0d expected 0/0", trg_cnt, lost_cnt);
    end
    rst = 1'b0; trg_in = '0; rdo_busy = 1'b0;
    exp_trg = 0; exp_lost = 0; exp_trg_s = 0; exp_lost_s = 0;
    cur_th = 1; cur_mask = '1; cur_dead = 10;
    tick();
    checks++;
    if ({trg_out, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_mid after trg/busy got %b expected 00", {trg_out, busy});
    end
    repeat (3) tick();
    clear_stim();
    for (int e = 1; e <= 3; e++) trg_a[e] = 5'b10000;
    run_window("reset_defaults");
  endtask

  task automatic test_thresh_zero();
    set_cfg(0, '1, 10);
    clear_stim();
    for (int e = 1; e <= 10; e++) trg_a[e] = '1;
    run_window("thresh_zero");
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_pulse();
    test_config();
    test_threshold();
    test_hold_lost();
    test_back_to_back();
    test_dead_live();
    test_random();
    test_saturation();
    test_reset_mid();
    test_thresh_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
